// File: rtl/switch_debounce_conditioner.sv
// Switch conditioner: 2-flop sync, per-bit debounce, rise/fall strobes.
// Ports: clk_clk, reset_reset_n, sw_raw -> sw_stable, sw_rise, sw_fall, sw_changed.
module switch_debounce_conditioner #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 0,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] flip;

  // A bit flips once its new level has been seen
  // on D consecutive edges (counter at D-1 now).
  always_comb begin
    flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flip[i] = (s2[i] != sw_stable[i]) &&
                (cnt[i] == LAST);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      s1         <= '0;
      s2         <= '0;
      sw_stable  <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= sw_raw ^ {WIDTH{INV}};
      s2 <= s1;
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == sw_stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + ONE;
        end
      end
      sw_stable  <= sw_stable ^ flip;
      sw_rise    <= flip & s2;
      sw_fall    <= flip & ~s2;
      sw_changed <= |flip;
    end
  end

endmodule

// File: tb/tb_switch_debounce_conditioner.sv
// Bench for switch_debounce_conditioner (D=4, WIDTH=5),
// one active-high and one active-low instance.
module tb_switch_debounce_conditioner;

  localparam int W = 5;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] raw     [2];
  logic [W-1:0] stable  [2];
  logic [W-1:0] rise    [2];
  logic [W-1:0] fall    [2];
  logic         changed [2];

  int tests = 0;
  int fails = 0;

  logic [W-1:0] rawh [2][$];
  logic [W-1:0] hist [2][$];
  logic [W-1:0] m_stable [2];
  logic [W-1:0] m_rise   [2];
  logic [W-1:0] m_fall   [2];
  logic [W-1:0] pulses;

  always #5 clk = ~clk;

  switch_debounce_conditioner #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(0)
  ) u_hi (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .sw_raw(raw[0]),
    .sw_stable(stable[0]),
    .sw_rise(rise[0]),
    .sw_fall(fall[0]),
    .sw_changed(changed[0])
  );

  switch_debounce_conditioner #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)
  ) u_lo (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .sw_raw(raw[1]),
    .sw_stable(stable[1]),
    .sw_rise(rise[1]),
    .sw_fall(fall[1]),
    .sw_changed(changed[1])
  );

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b",
             tag, obs, exp);
    end
  endtask

  // Reference: the synchronised level seen at edge k is
  // the conditioned input sampled two edges earlier (zero
  // right after reset). A bit accepts its new level when
  // the last D synchronised samples all disagree with it.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] in_n;
      logic [W-1:0] s2u;
      logic [W-1:0] nxt;
      int           n;
      bit           all;
      if (!rst_n) begin
        rawh[k].delete();
        hist[k].delete();
        m_stable[k] = '0;
        m_rise[k]   = '0;
        m_fall[k]   = '0;
      end else begin
        in_n = raw[k] ^ ((k == 1) ? 5'b11111 : 5'b00000);
        n = rawh[k].size();
        s2u = (n >= 2) ? rawh[k][n-2] : '0;
        rawh[k].push_back(in_n);
        hist[k].push_back(s2u);
        if (rawh[k].size() > 16) void'(rawh[k].pop_front());
        if (hist[k].size() > 16) void'(hist[k].pop_front());
        nxt = m_stable[k];
        m_rise[k] = '0;
        m_fall[k] = '0;
        n = hist[k].size();
        if (n >= D) begin
          for (int b = 0; b < W; b++) begin
            all = 1'b1;
            for (int j = 0; j < D; j++) begin
              if (hist[k][n-1-j][b] == m_stable[k][b])
                all = 1'b0;
            end
            if (all) begin
              nxt[b] = ~m_stable[k][b];
              if (nxt[b]) m_rise[k][b] = 1'b1;
              else        m_fall[k][b] = 1'b1;
            end
          end
        end
        m_stable[k] = nxt;
      end
    end
  endtask

  task automatic tick(input logic [W-1:0] r0,
                      input logic [W-1:0] r1,
                      input logic         rn);
    @(negedge clk);
    raw[0] = r0;
    raw[1] = r1;
    rst_n  = rn;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stable%0d", k), stable[k], m_stable[k]);
      chk($sformatf("rise%0d", k), rise[k], m_rise[k]);
      chk($sformatf("fall%0d", k), fall[k], m_fall[k]);
      chk($sformatf("changed%0d", k), {4'b0, changed[k]},
          {4'b0, |(m_rise[k] | m_fall[k])});
      if (k == 0) pulses = pulses | rise[0] | fall[0];
    end
  endtask

  // Hold r0 and count edges until stable[0] moves.
  task automatic wait_change(input logic [W-1:0] r0,
                             input int exp_n,
                             input string tag);
    logic [W-1:0] start;
    int  n;
    bit  done;
    start = stable[0];
    n = 0;
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      tick(r0, 5'b11111, 1'b1);
      n++;
      if (stable[0] !== start) done = 1'b1;
    end
    chk(tag, W'(n), W'(exp_n));
  endtask

  initial begin
    rst_n  = 1'b0;
    raw[0] = '0;
    raw[1] = 5'b11111;
    pulses = '0;

    // 1: reset, then quiet input
    tick(5'b0, 5'b11111, 1'b0);
    tick(5'b0, 5'b11111, 1'b0);
    chk("rst_stable", stable[0], 5'b0);
    chk("rst_rise", rise[0], 5'b0);
    chk("rst_fall", fall[0], 5'b0);
    chk("rst_changed", {4'b0, changed[0]}, 5'b0);
    pulses = '0;
    for (int i = 0; i < 20; i++) tick(5'b0, 5'b11111, 1'b1);
    chk("idle_pulses", pulses, 5'b0);

    // 2: single bit held high
    wait_change(5'b00001, 6, "t2_latency");
    chk("t2_stable", stable[0], 5'b00001);
    chk("t2_rise", rise[0], 5'b00001);
    chk("t2_changed", {4'b0, changed[0]}, 5'b00001);
    tick(5'b00001, 5'b11111, 1'b1);
    chk("t2_rise_off", rise[0], 5'b0);
    chk("t2_changed_off", {4'b0, changed[0]}, 5'b0);

    // 3: 3-cycle glitch on bit 2 is filtered
    pulses = '0;
    for (int i = 0; i < 3; i++) tick(5'b00101, 5'b11111, 1'b1);
    for (int i = 0; i < 10; i++) tick(5'b00001, 5'b11111, 1'b1);
    chk("t3_stable", stable[0], 5'b00001);
    chk("t3_pulses", pulses, 5'b0);

    // 4: bouncing bit 3 then held
    tick(5'b01001, 5'b11111, 1'b1);
    tick(5'b00001, 5'b11111, 1'b1);
    tick(5'b01001, 5'b11111, 1'b1);
    tick(5'b00001, 5'b11111, 1'b1);
    wait_change(5'b01001, 6, "t4_latency");
    chk("t4_rise", rise[0], 5'b01000);
    tick(5'b01001, 5'b11111, 1'b1);
    chk("t4_rise_off", rise[0], 5'b0);

    // 5: simultaneous multi-bit transition
    wait_change(5'b00011, 6, "t5_pre");
    chk("t5_pre_stable", stable[0], 5'b00011);
    wait_change(5'b11100, 6, "t5_latency");
    chk("t5_stable", stable[0], 5'b11100);
    chk("t5_rise", rise[0], 5'b11100);
    chk("t5_fall", fall[0], 5'b00011);
    chk("t5_changed", {4'b0, changed[0]}, 5'b00001);
    tick(5'b11100, 5'b11111, 1'b1);
    chk("t5_changed_off", {4'b0, changed[0]}, 5'b0);

    // 6: reset mid-count, then full latency again
    for (int i = 0; i < 4; i++) tick(5'b11111, 5'b11111, 1'b1);
    tick(5'b11111, 5'b11111, 1'b0);
    chk("t6_rst_stable", stable[0], 5'b0);
    wait_change(5'b11111, 6, "t6_latency");
    chk("t6_rise", rise[0], 5'b11111);
    chk("t6_lo_stable", stable[1], 5'b0);

    // random segments with occasional reset
    for (int s = 0; s < 120; s++) begin
      logic [W-1:0] r0;
      logic [W-1:0] r1;
      int           hold;
      r0 = W'($urandom);
      r1 = W'($urandom);
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        if ($urandom_range(0, 79) == 0)
          tick(r0, r1, 1'b0);
        else
          tick(r0, r1, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
